frame_filler: RTL and testbench
===============================

FRAME_FILLER -- requirements
Module: frame_filler

Interface
REQ-001 Parameter WORD_W, default 12, output word width.
REQ-002 Parameter PTR_W, default 9, buffer read pointer width.
REQ-003 Parameter FRAME_LEN, default 512, valid pointer range 0..FRAME_LEN-1.
REQ-004 Parameter FRM_CNT_W, default 8, frame counter width; frame slot fixed at pointer 0.
REQ-005 Parameter GRP_PTR, default 149, group-counter slot pointer.
REQ-006 Parameter GRP_CNT_W, default 10, group counter width.
REQ-007 Parameter SUB_OFFSET, default 2, first sub-slot pointer.
REQ-008 Parameter SUB_PERIOD, default 16, spacing of sub-slots.
REQ-009 Parameter SUB_CNT_W, default 8, sub-slot counter width.
REQ-010 Parameter GRP_SEL_W, default 5, width of cntGrp.
REQ-011 clk  input  1  system clock, all logic on rising edge.
REQ-012 reset  input  1  asynchronous, active-low reset.
REQ-013 bufGetWord  input  1  word request strobe, one word per high cycle.
REQ-014 bufRdPointer  input  PTR_W  slot index of requested word.
REQ-015 cntGrp  input  GRP_SEL_W  group phase; 0 marks the group-counter advance frame.
REQ-016 mode  input  2  0 normal, 1 pointer ramp, 2 constant fill, 3 frozen counters.
REQ-017 dataWord  output  WORD_W  registered data word.
REQ-018 dataValid  output  1  one-cycle pulse, dataWord updated this cycle.
REQ-019 ptrErr  output  1  sticky flag, out-of-range pointer seen.

Function
REQ-020 Elaboration SHALL fail if WORD_W < max(FRM_CNT_W,SUB_CNT_W)+4, WORD_W < GRP_CNT_W+2, or GRP_PTR collides with pointer 0 or any sub-slot.
REQ-021 Sub-slots SHALL be pointers p < FRAME_LEN with p >= SUB_OFFSET and (p-SUB_OFFSET) mod SUB_PERIOD = 0.
REQ-022 On a clk edge with bufGetWord=1, dataWord SHALL load the word for bufRdPointer and dataValid SHALL be 1 the following cycle; latency exactly 1 clock.
REQ-023 With bufGetWord=0, dataWord SHALL hold and dataValid SHALL be 0.
REQ-024 Mode 0/3 frame slot word: MSB 0, frame counter zero-extended in middle, low 3 bits 3'b001.
REQ-025 Mode 0/3 group slot word: MSB 0, group counter zero-extended, LSB 0.
REQ-026 Mode 0/3 sub-slot word: MSB 0, sub counter zero-extended, low 3 bits 3'b011.
REQ-027 Mode 0/3 any other in-range pointer: fill word, all bits 0 except bit1 = 1 (value 2).
REQ-028 Mode 1: dataWord SHALL equal bufRdPointer zero-extended/truncated to WORD_W; counters advance as mode 0.
REQ-029 Mode 2: dataWord SHALL equal fill word (2) for every pointer; counters advance as mode 0.
REQ-030 Words SHALL carry the counter value before any increment from the same request.
REQ-031 An access is "first" when bufRdPointer differs from the last serviced pointer, or it is the first request after reset.
REQ-032 Frame counter SHALL increment by 1 on first access of pointer 0.
REQ-033 Group counter SHALL increment by 1 on first access of GRP_PTR only when cntGrp = 0.
REQ-034 Sub counter SHALL increment by 1 on first access of each sub-slot.
REQ-035 Repeated consecutive requests of one pointer SHALL return the same word and SHALL NOT increment.
REQ-036 All counters SHALL wrap modulo 2^width without flag.
REQ-037 Mode 3 SHALL suppress all counter increments; last-pointer tracking still updates.
REQ-038 Pointer >= FRAME_LEN: dataWord = fill word, dataValid pulses, no counter change, ptrErr set to 1 and held until reset.
REQ-039 mode SHALL be sampled only on request cycles; a change takes effect on the next request.

Reset
REQ-040 On reset low: dataWord = 0, dataValid = 0, ptrErr = 0, all counters = 0, last-pointer tracking invalidated, immediately and independent of clk.
REQ-041 Reset asserted mid-frame SHALL abort without partial counter update; first request after release is treated as first access.

Verification
REQ-042 Reset, mode 0, request pointer 0 twice then 1 -> words 0x001, 0x001, 0x002; next frame pointer 0 -> 0x009.
REQ-043 Mode 0, frames with cntGrp=3 then 0, request 149 each -> 0x000 both times, next cntGrp=0 frame -> 0x002.
REQ-044 Mode 0, request 2,18,34 -> 0x003, 0x00B, 0x013; 256 sub-slot accesses -> counter wraps to 0, word 0x003.
REQ-045 Mode 1 pointer 300 -> 0x12C; mode 3 pointer 0 three frames -> frame counter field unchanged.
REQ-046 Pointer 511 in FRAME_LEN=500 build -> 0x002, ptrErr=1, stays 1 until reset.
REQ-047 Reset pulsed between requests -> dataWord 0 immediately, next pointer 0 -> 0x001; bufGetWord=0 cycles -> dataValid 0, dataWord held.

Source files
------------

// File: rtl/frame_filler.sv
// frame_filler: per-request word generator for a fixed-length frame buffer.
// Counter slots carry frame/group/sub-slot counters; all other slots return a fill word.
module frame_filler #(
  parameter int WORD_W     = 12,
  parameter int PTR_W      = 9,
  parameter int FRAME_LEN  = 512,
  parameter int FRM_CNT_W  = 8,
  parameter int GRP_PTR    = 149,
  parameter int GRP_CNT_W  = 10,
  parameter int SUB_OFFSET = 2,
  parameter int SUB_PERIOD = 16,
  parameter int SUB_CNT_W  = 8,
  parameter int GRP_SEL_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bufGetWord,
  input  logic [PTR_W-1:0]     bufRdPointer,
  input  logic [GRP_SEL_W-1:0] cntGrp,
  input  logic [1:0]           mode,
  output logic [WORD_W-1:0]    dataWord,
  output logic                 dataValid,
  output logic                 ptrErr
);
  localparam int MAX_CW = FRM_CNT_W > SUB_CNT_W ? FRM_CNT_W : SUB_CNT_W;
  localparam logic [WORD_W-1:0] FILL = WORD_W'(2);
  generate
    if (WORD_W < MAX_CW + 4 || WORD_W < GRP_CNT_W + 2)
      begin : g_bad_width
        $error("frame_filler: WORD_W too narrow for counter fields");
      end
    if (GRP_PTR == 0 || (GRP_PTR >= SUB_OFFSET && GRP_PTR < FRAME_LEN && (GRP_PTR - SUB_OFFSET) % SUB_PERIOD == 0))
      begin : g_bad_grp
        $error("frame_filler: GRP_PTR collides with frame slot or a sub-slot");
      end
  endgenerate
  logic [FRM_CNT_W-1:0] r_frm;
  logic [GRP_CNT_W-1:0] r_grp;
  logic [SUB_CNT_W-1:0] r_sub;
  logic [PTR_W-1:0]     r_last;
  logic                 r_last_vld;
  logic [31:0]          w_p32;
  logic                 w_oor, w_frm_slot, w_grp_slot, w_sub_slot, w_first, w_inc;
  logic [WORD_W-1:0]    w_word;
  assign w_p32      = 32'(bufRdPointer);
  assign w_oor      = w_p32 >= FRAME_LEN;
  assign w_frm_slot = bufRdPointer == '0;
  assign w_grp_slot = w_p32 == GRP_PTR;
  assign w_sub_slot = w_p32 >= SUB_OFFSET && (w_p32 - SUB_OFFSET) % SUB_PERIOD == 0;
  assign w_first    = !r_last_vld || bufRdPointer != r_last;
  assign w_inc      = bufGetWord && w_first && !w_oor && mode != 2'd3;
  always_comb begin
    w_word = w_oor        ? FILL :
             mode == 2'd1 ? WORD_W'(bufRdPointer) :
             mode == 2'd2 ? FILL :
             w_frm_slot   ? {1'b0, (WORD_W-4)'(r_frm), 3'b001} :
             w_grp_slot   ? {1'b0, (WORD_W-2)'(r_grp), 1'b0} :
             w_sub_slot   ? {1'b0, (WORD_W-4)'(r_sub), 3'b011} : FILL;
  end
  // A repeat of the last serviced pointer replays the previous word untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataWord   <= '0;
      dataValid  <= 1'b0;
      ptrErr     <= 1'b0;
      r_frm      <= '0;
      r_grp      <= '0;
      r_sub      <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else begin
      dataValid <= bufGetWord;
      if (bufGetWord) begin
        if (w_first) dataWord <= w_word;
        if (w_oor) ptrErr <= 1'b1;
        r_last     <= bufRdPointer;
        r_last_vld <= 1'b1;
      end
      if (w_inc && w_frm_slot) r_frm <= r_frm + 1'b1;
      if (w_inc && w_grp_slot && cntGrp == '0) r_grp <= r_grp + 1'b1;
      if (w_inc && w_sub_slot) r_sub <= r_sub + 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_filler.sv
// tb_frame_filler: randomized and directed checks of frame_filler against a
// slot/counter reference model; a second build with FRAME_LEN=500 covers range errors.
module tb_frame_filler;
  logic clk = 1'b0;
  logic reset;
  logic bufGetWord, g5;
  logic [8:0] bufRdPointer, p5;
  logic [4:0] cntGrp;
  logic [1:0] mode;
  logic [11:0] dataWord, w5;
  logic dataValid, ptrErr, v5, e5;
  int n_checks = 0;
  int n_errors = 0;
  int m_frm, m_grp, m_sub, m_last, m_word;
  bit m_lv;
  frame_filler dut (
    .clk(clk), .reset(reset), .bufGetWord(bufGetWord), .bufRdPointer(bufRdPointer),
    .cntGrp(cntGrp), .mode(mode), .dataWord(dataWord), .dataValid(dataValid), .ptrErr(ptrErr)
  );
  frame_filler #(.FRAME_LEN(500)) dut500 (
    .clk(clk), .reset(reset), .bufGetWord(g5), .bufRdPointer(p5),
    .cntGrp(5'd0), .mode(2'd0), .dataWord(w5), .dataValid(v5), .ptrErr(e5)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_frm = 0; m_grp = 0; m_sub = 0; m_last = 0; m_word = 0; m_lv = 0;
  endtask
  function automatic bit is_sub(input int p);
    return p >= 2 && (p - 2) % 16 == 0;
  endfunction
  task automatic model_req(input int p, input int cg, input int m);
    bit first;
    first = !m_lv || p != m_last;
    if (first) begin
      if (m == 1) m_word = p;
      else if (m == 2) m_word = 2;
      else if (p == 0) m_word = m_frm * 8 + 1;
      else if (p == 149) m_word = m_grp * 2;
      else if (is_sub(p)) m_word = m_sub * 8 + 3;
      else m_word = 2;
      if (m != 3) begin
        if (p == 0) m_frm = (m_frm + 1) % 256;
        if (p == 149 && cg == 0) m_grp = (m_grp + 1) % 1024;
        if (is_sub(p)) m_sub = (m_sub + 1) % 256;
      end
    end
    m_last = p;
    m_lv = 1;
  endtask
  task automatic req(input int p, input int cg, input int m);
    @(negedge clk);
    bufGetWord = 1'b1; bufRdPointer = 9'(p); cntGrp = 5'(cg); mode = 2'(m);
    model_req(p, cg, m);
    @(posedge clk); #1;
    check("word", dataWord, m_word);
    check("valid", dataValid, 1);
    check("perr", ptrErr, 0);
  endtask
  task automatic idle();
    @(negedge clk);
    bufGetWord = 1'b0; bufRdPointer = 9'($urandom_range(0, 511)); mode = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    check("idle_valid", dataValid, 0);
    check("idle_word", dataWord, m_word);
  endtask
  task automatic rst();
    @(negedge clk);
    bufGetWord = 1'b0; g5 = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_word", dataWord, 0);
    check("rst_valid", dataValid, 0);
    check("rst_perr", ptrErr, 0);
    check("rst_perr500", e5, 0);
    check("rst_word500", w5, 0);
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic req5(input int p, input int exp_w, input int exp_e);
    @(negedge clk);
    g5 = 1'b1; p5 = 9'(p);
    @(posedge clk); #1;
    check("w500", w5, exp_w);
    check("v500", v5, 1);
    check("e500", e5, exp_e);
  endtask
  initial begin
    int r, c, p;
    reset = 1'b0; bufGetWord = 1'b0; bufRdPointer = '0; cntGrp = '0; mode = '0;
    g5 = 1'b0; p5 = '0;
    model_reset();
    #12;
    check("init_word", dataWord, 0);
    check("init_valid", dataValid, 0);
    check("init_perr", ptrErr, 0);
    @(negedge clk) reset = 1'b1;
    // frame slot: repeat replays, next first access shows incremented count
    req(0, 1, 0); check("f0a", dataWord, 'h001);
    req(0, 1, 0); check("f0b", dataWord, 'h001);
    req(1, 1, 0); check("f1", dataWord, 'h002);
    req(0, 1, 0); check("f0c", dataWord, 'h009);
    // group slot advances only on cntGrp==0 frames
    req(149, 3, 0); check("g3", dataWord, 'h000);
    req(1, 3, 0);
    req(149, 0, 0); check("g0a", dataWord, 'h000);
    req(1, 0, 0);
    req(149, 0, 0); check("g0b", dataWord, 'h002);
    req(2, 1, 0); check("s2", dataWord, 'h003);
    req(18, 1, 0); check("s18", dataWord, 'h00b);
    req(34, 1, 0); check("s34", dataWord, 'h013);
    for (int i = 3; i < 256; i++) req(2 + 16 * (i % 32), 1, 0);
    req(2, 1, 0); check("s_wrap", dataWord, 'h003);
    req(300, 1, 1); check("ramp300", dataWord, 'h12c);
    for (int i = 0; i < 3; i++) begin
      req(0, 1, 3); check("frozen", dataWord, 'h011);
      req(7, 1, 3);
    end
    req(0, 1, 0); check("unfrozen", dataWord, 'h011);
    for (int i = 0; i < 3; i++) idle();
    check("held", dataWord, 'h011);
    req(0, 1, 0); check("replay", dataWord, 'h011);
    rst();
    req(0, 1, 0); check("post_rst0", dataWord, 'h001);
    req(1, 1, 0);
    req(0, 1, 0); check("post_rst1", dataWord, 'h009);
    rst();
    req5(499, 2, 0);
    req5(500, 2, 1);
    req5(0, 1, 1);
    req5(511, 2, 1);
    req5(0, 9, 1);
    @(negedge clk) g5 = 1'b0;
    @(posedge clk); #1;
    check("e500_sticky", e5, 1);
    check("v500_idle", v5, 0);
    rst();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) rst();
      else if (r < 12) idle();
      else begin
        c = $urandom_range(0, 5);
        p = c == 0 ? 0 : c == 1 ? 149 : c == 2 ? 2 + 16 * $urandom_range(0, 31) :
            c == 3 ? m_last : $urandom_range(0, 511);
        req(p, $urandom_range(0, 2), $urandom_range(0, 9) < 6 ? 0 : $urandom_range(1, 3));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
